// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_DOT = 3'b100;
   localparam logic [2:0] OP_LDW = 3'b101;
   localparam logic [2:0] OP_LDX = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DOT  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_regbank.sv
// NW x WIDTH register bank: one range-checked write port, one combinational read port.
module alu_regbank
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NW    = 3,
   parameter int IW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [IW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [IW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             oob_o
);

   localparam logic [IW:0] NW_C = (IW+1)'(NW);

   logic [WIDTH-1:0] mem_q [NW];
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = {1'b0, waddr_i} < NW_C;
   assign rd_ok = {1'b0, raddr_i} < NW_C;
   assign oob_o = ~wr_ok;

   // Out-of-range indices read as zero rather than aliasing another entry.
   assign rdata_o = rd_ok ? mem_q[raddr_i] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) mem_q[i] <= '0;
      end else if (we_i && wr_ok) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle ops plus an NW-term dot product
// over loadable weight/input banks, issued with a start/busy/done handshake.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NW    = 3,
   parameter int IW    = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] y,
   output logic             done,
   output logic             busy,
   output logic             zero,
   output logic             ovf,
   output logic             err,
   output logic             state_o
);

   // Handshake: a request is taken on a rising edge where start=1 and busy=0;
   // done pulses for one cycle per accepted request, and y/flags hold until the next done.

   localparam logic [IW:0] K_LAST = (IW+1)'(NW - 1);

   state_t           state_q, state_d;
   logic [IW:0]      k_q, k_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             w_we, x_we;
   logic             w_oob, x_oob;
   logic [WIDTH-1:0] w_rd, x_rd;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] res;
   logic             res_ovf;
   logic             res_err;

   alu_regbank #(.WIDTH(WIDTH), .NW(NW), .IW(IW)) u_wbank (
      .clk(clk), .rst(rst), .we_i(w_we), .waddr_i(A[IW-1:0]), .wdata_i(B),
      .raddr_i(k_q[IW-1:0]), .rdata_o(w_rd), .oob_o(w_oob)
   );

   alu_regbank #(.WIDTH(WIDTH), .NW(NW), .IW(IW)) u_xbank (
      .clk(clk), .rst(rst), .we_i(x_we), .waddr_i(A[IW-1:0]), .wdata_i(B),
      .raddr_i(k_q[IW-1:0]), .rdata_o(x_rd), .oob_o(x_oob)
   );

   assign prod = x_rd * w_rd;

   always_comb begin
      res     = '0;
      res_ovf = 1'b0;
      res_err = 1'b0;
      case (op)
         OP_ADD: begin
            res     = A + B;
            res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            res     = A - B;
            res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_LDW: begin
            res     = B;
            res_err = w_oob;
         end
         OP_LDX: begin
            res     = B;
            res_err = x_oob;
         end
         OP_SLT: res[0] = $signed(A) < $signed(B);
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      y_d     = y_q;
      done_d  = 1'b0;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      w_we    = 1'b0;
      x_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_DOT) begin
                  state_d = ST_DOT;
                  k_d     = '0;
                  acc_d   = '0;
               end else begin
                  w_we   = (op == OP_LDW);
                  x_we   = (op == OP_LDX);
                  y_d    = res;
                  zero_d = (res == '0);
                  ovf_d  = res_ovf;
                  err_d  = res_err;
                  done_d = 1'b1;
               end
            end
         end
         ST_DOT: begin
            acc_d = acc_q + prod;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d = ST_IDLE;
               y_d     = acc_d;
               zero_d  = (acc_d == '0);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign y       = y_q;
   assign done    = done_q;
   assign busy    = (state_q == ST_DOT);
   assign zero    = zero_q;
   assign ovf     = ovf_q;
   assign err     = err_q;
   assign state_o = state_q;

endmodule
